// File: rtl/strength_window.sv
// strength_window: producer side of the hysteresis strength interface.
// Buffers two lines of 2-bit strength classes and emits one packed 3x3
// neighbourhood per interior pixel. The classes are 00 none, 01 weak,
// 10 strong and 11 reserved, and all of them pass through unmodified.
// There is no backpressure. A pixel is accepted on every cycle that
// class_valid is high.

module strength_window #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sof,
   input  logic [1:0]  class_in,
   input  logic        class_valid,
   output logic [17:0] strength,
   output logic        str_valid,
   output logic        frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
   localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

   // Raster position of the pixel currently being accepted.
   logic [CW-1:0] col_q;
   logic [CW-1:0] col_d;
   logic [CW-1:0] pix_col;
   logic [RW-1:0] row_q;
   logic [RW-1:0] row_d;
   logic [RW-1:0] pix_row;

   logic accept;
   logic emit;
   logic last_pix;

   // lb1 holds line row-1 and lb0 holds line row-2.
   logic [1:0] lb0 [IMG_WIDTH];
   logic [1:0] lb1 [IMG_WIDTH];
   logic [1:0] lb0_rd;
   logic [1:0] lb1_rd;

   // The 3x3 window is packed in the output layout: field i = r*3+c sits at
   // bits [2i+1:2i]. Row 0 is the oldest (top) row. Column 0 is the oldest
   // (left) column.
   logic [17:0] win_q;
   logic [17:0] win_d;

   // Resolve the effective pixel position and decide whether this accept emits.
   always_comb begin
      // NOTE: every signal gets a default before any branch so that none of
      // them can keep an old value across evaluations. Without the defaults
      // a latch would be inferred.
      accept   = class_valid;
      pix_col  = col_q;
      pix_row  = row_q;
      if (sof) begin
         // sof forces the pixel to (0,0). The partial frame is dropped.
         pix_col = '0;
         pix_row = '0;
      end
      emit     = accept && !sof &&
                 (pix_row >= ROW_FIRST_WIN) && (pix_col >= COL_FIRST_WIN);
      last_pix = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
   end

   // Compute the next raster position. It wraps at end of line and end of frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (pix_col == COL_LAST) begin
            col_d = '0;
            row_d = (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
         end else begin
            col_d = pix_col + CW'(1);
            row_d = pix_row;
         end
      end
   end

   // Column and row counter registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is written only with non-blocking
      // assignments, so that every register samples its pre-edge inputs.
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Line-buffer read ports, addressed by the column of the accepted pixel.
   assign lb0_rd = lb0[pix_col];
   assign lb1_rd = lb1[pix_col];

   // Line-buffer write: move line row-1 down to row-2, then store the new pixel.
   always_ff @(posedge clk) begin
      // NOTE: the line buffers have no reset, so they map onto plain RAM.
      // Stale content never reaches the output. The row gate on emission
      // only opens after two lines of the current frame have been written
      // at every column.
      if (accept) begin
         lb0[pix_col] <= lb1[pix_col];
         lb1[pix_col] <= class_in;
      end
   end

   // Window next state: shift left one column and load the new right column.
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[(r*3 + 0)*2 +: 2] = win_q[(r*3 + 1)*2 +: 2];
            win_d[(r*3 + 1)*2 +: 2] = win_q[(r*3 + 2)*2 +: 2];
         end
         win_d[5:4]   = lb0_rd;     // top row, field 2
         win_d[11:10] = lb1_rd;     // middle row, field 5
         win_d[17:16] = class_in;   // bottom row, field 8: the newest pixel
      end
   end

   // Window registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q <= '0;
      end else begin
         win_q <= win_d;
      end
   end

   // Registered output. strength holds its last value between windows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strength   <= '0;
         str_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         str_valid  <= emit;
         frame_done <= emit && last_pix;
         if (emit) begin
            strength <= win_d;
         end
      end
   end

endmodule

// File: tb/tb_strength_window.sv
// Self-checking bench for strength_window on a 5x4 image.
// The reference model keeps the whole current frame in a 2-D array. It
// indexes pixels with a linear counter and builds each expected window
// directly from the image.

module tb_strength_window;

   localparam int W = 5;
   localparam int H = 4;

   logic        clk;
   logic        rst;
   logic        sof;
   logic [1:0]  class_in;
   logic        class_valid;
   logic [17:0] strength;
   logic        str_valid;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   logic [1:0]  img [H][W];
   int          p;
   logic [17:0] exp_strength;

   // Observation counters used by the directed scenario checks.
   int          obs_win;
   int          obs_done;
   int          obs_aaa;
   logic [17:0] first_win;

   strength_window #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sof         (sof),
      .class_in    (class_in),
      .class_valid (class_valid),
      .strength    (strength),
      .str_valid   (str_valid),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   task automatic clear_obs();
      obs_win   = 0;
      obs_done  = 0;
      obs_aaa   = 0;
      first_win = '0;
   endtask

   task automatic model_reset();
      p            = 0;
      exp_strength = '0;
   endtask

   // Apply one cycle of input and predict the result with the model.
   // Then check the outputs just after the edge.
   task automatic drive(input logic v, input logic s, input logic [1:0] c);
      logic ev;
      logic ed;
      int   row;
      int   col;
      ev = 1'b0;
      ed = 1'b0;
      class_valid = v;
      sof         = s;
      class_in    = c;
      if (v) begin
         if (s) p = 0;
         row = p / W;
         col = p % W;
         img[row][col] = c;
         if (!s && row >= 2 && col >= 2) begin
            ev = 1'b1;
            for (int r = 0; r < 3; r++)
               for (int cc = 0; cc < 3; cc++)
                  exp_strength[(r*3 + cc)*2 +: 2] = img[row-2+r][col-2+cc];
            ed = (p == W*H - 1);
         end
         p = (p + 1) % (W*H);
      end
      @(posedge clk);
      #1;
      check("str_valid", 32'(str_valid), 32'(ev));
      check("frame_done", 32'(frame_done), 32'(ed));
      check("strength", 32'(strength), 32'(exp_strength));
      if (str_valid === 1'b1) begin
         if (obs_win == 0) first_win = strength;
         obs_win++;
         if (strength === 18'h2AAAA) obs_aaa++;
      end
      if (frame_done === 1'b1) obs_done++;
   endtask

   // Send npix pixels in raster order from (0,0).
   // kind 0: all 01 with (1,1)=10.  kind 1: all 10.
   // kind 2: all 00 with (2,2)=11.  kind 3: random.
   // gap 0: continuous.  gap 1: idle after every pixel.  gap 2: random idles.
   // sof and class_in carry random values on idle cycles.
   task automatic frame(input int kind, input bit first_sof, input int gap, input int npix);
      int          r;
      int          c;
      logic [1:0]  cls;
      for (int i = 0; i < npix; i++) begin
         r = i / W;
         c = i % W;
         case (kind)
            0:       cls = (r == 1 && c == 1) ? 2'b10 : 2'b01;
            1:       cls = 2'b10;
            2:       cls = (r == 2 && c == 2) ? 2'b11 : 2'b00;
            default: cls = 2'($urandom);
         endcase
         drive(1'b1, first_sof && (i == 0), cls);
         if (gap == 1) begin
            drive(1'b0, 1'($urandom), 2'($urandom));
         end else if (gap == 2 && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) drive(1'b0, 1'($urandom), 2'($urandom));
         end
      end
   endtask

   // Pulse rst for one cycle, starting just after a clock edge.
   task automatic pulse_reset();
      rst         = 1'b1;
      class_valid = 1'b0;
      sof         = 1'b0;
      #1;
      check("rst_str_valid", 32'(str_valid), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_strength", 32'(strength), 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_str_valid", 32'(str_valid), 32'd0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst         = 1'b1;
      sof         = 1'b0;
      class_valid = 1'b0;
      class_in    = 2'b00;
      model_reset();
      clear_obs();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 2'b00;

      // Reset state.
      #2;
      check("reset_strength", 32'(strength), 32'd0);
      check("reset_str_valid", 32'(str_valid), 32'd0);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Continuous frame. There is a strong pixel at (1,1).
      clear_obs();
      frame(0, 1'b1, 0, W*H);
      check("t1_windows", 32'(obs_win), 32'd6);
      check("t1_first", 32'(first_win), 32'h15655);
      check("t1_done", 32'(obs_done), 32'd1);
      drive(1'b0, 1'b0, 2'b00);

      // Same frame with class_valid toggling each cycle.
      clear_obs();
      frame(0, 1'b1, 1, W*H);
      check("t2_windows", 32'(obs_win), 32'd6);
      check("t2_first", 32'(first_win), 32'h15655);
      check("t2_done", 32'(obs_done), 32'd1);

      // Two back-to-back frames. The second has no sof and is all strong.
      clear_obs();
      frame(0, 1'b1, 0, W*H);
      frame(1, 1'b0, 0, W*H);
      check("t3_windows", 32'(obs_win), 32'd12);
      check("t3_done", 32'(obs_done), 32'd2);
      check("t3_all_strong", 32'(obs_aaa), 32'd6);

      // sof at pixel (2,3) in mid-frame, then a full random frame.
      frame(0, 1'b1, 0, 2*W + 3);
      clear_obs();
      frame(3, 1'b1, 0, W*H);
      check("t4_windows", 32'(obs_win), 32'd6);
      check("t4_done", 32'(obs_done), 32'd1);

      // Reset during row 3. The next frame is sent without sof.
      frame(3, 1'b1, 0, 3*W + 1);
      pulse_reset();
      clear_obs();
      frame(3, 1'b0, 2, W*H);
      check("t5_windows", 32'(obs_win), 32'd6);
      check("t5_done", 32'(obs_done), 32'd1);

      // Reserved code 11 at (2,2) must pass through unchanged.
      clear_obs();
      frame(2, 1'b1, 0, W*H);
      check("t6_first", 32'(first_win), 32'h30000);
      check("t6_windows", 32'(obs_win), 32'd6);

      // Random frames with random gaps and an occasional sof.
      for (int f = 0; f < 8; f++) begin
         clear_obs();
         frame(3, (f == 0) || ($urandom_range(0, 1) == 1), 2, W*H);
         check("rand_windows", 32'(obs_win), 32'd6);
         check("rand_done", 32'(obs_done), 32'd1);
      end
      drive(1'b0, 1'b0, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/strength_window.md
Name: strength_window

Overview:
- Producer side of the hysteresis strength interface. Accepts a raster stream of 2-bit per-pixel strength classes from the double-threshold stage: 00 none, 01 weak, 10 strong, 11 reserved.
- Buffers two image lines and emits one packed 3x3 neighbourhood per interior pixel on the 18-bit strength bus, qualified by str_valid.
- Output drives the hysteresis stage directly. There is no backpressure.

Parameters:
- IMG_WIDTH, 640, pixels per line; legal range 3 or more.
- IMG_HEIGHT, 480, lines per frame; legal range 3 or more.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sof  input  1  start of frame; qualified by class_valid; marks pixel (0,0).
- class_in  input  2  strength class of incoming pixel.
- class_valid  input  1  class_in and sof valid this cycle; a pixel is accepted every cycle this is high.
- strength  output  18  packed 3x3 window; field i at bits [2i+1:2i], i = r*3+c.
- str_valid  output  1  strength valid, one-cycle qualifier per window.
- frame_done  output  1  one-cycle pulse, coincident with str_valid of the last window of a frame.

Behaviour:
- Reset (async assert, sync release):
  - strength=0, str_valid=0, frame_done=0.
  - Column/row counters=0; window registers=0.
  - Line-buffer RAMs are not reset; stale content is masked by gating.
- Counters:
  - col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 identify the accepted pixel.
  - On accept: col increments. At IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0, so back-to-back frames work without sof.
  - Accept with sof=1: the pixel is treated as (0,0) regardless of counters and the partial frame is abandoned. Counters advance to (0,1).
- Line buffers:
  - lb1 holds line row-1, lb0 holds line row-2, each IMG_WIDTH x 2 bits.
  - On accept at column col: read lb0[col] and lb1[col], then write lb0[col]<=lb1[col] and lb1[col]<=class_in.
- Window:
  - 3 columns x 3 rows of 2-bit registers.
  - On accept, shift left one column and load the new right column: top=lb0[col], mid=lb1[col], bottom=class_in.
  - No shift when class_valid=0; gaps are transparent.
- Packing:
  - r=0 is the top (oldest) row and c=0 the left (oldest) column.
  - Index 4 (bits 9:8) is the centre. Index 8 (bits 17:16) is the pixel just accepted.
  - Classes pass through unmodified, 11 included.
- Emission:
  - The accepted pixel at (row,col) with row>=2 and col>=2 produces a window centred at (row-1,col-1).
  - strength and str_valid are registered and appear the cycle after the accept.
  - Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Border pixels get no window.
  - When str_valid=0, strength holds its last value.
- frame_done is high with str_valid exactly when the emitting pixel is (IMG_HEIGHT-1, IMG_WIDTH-1).
- Latency: pixel to first window containing it as bottom-right is 1 cycle. Pixel to its centred window is IMG_WIDTH+1 accepts + 1 cycle.
- An accept with sof=1 never emits, even when counters said row>=2 and col>=2.
- Rows 0/1 after sof: lb contents from the prior frame are masked by the row gate.
- Reset mid-frame: all outputs drop immediately; the next frame needs no sof but sof is honoured.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, all pixels 01, pixel (1,1)=10, class_valid continuous with sof on first pixel -> 6 windows. First window = 18'h15655, one cycle after accepting pixel (2,2). Remaining windows = 18'h15555 except those containing (1,1) at the right index. frame_done with the 6th window only.
- Same frame with class_valid toggling 1,0 each cycle -> identical 6 strength values in the same order. str_valid only on the cycle after accepts.
- Two back-to-back frames, no second sof, second frame all 10 -> second frame windows all 18'h2AAAA, 12 str_valid total, two frame_done pulses.
- sof asserted at pixel (2,3) mid-frame, followed by a full frame -> no window for the sof pixel. Exactly 6 windows from the new frame, matching the golden model.
- rst asserted for 1 cycle during row 3 -> str_valid and frame_done are 0 that cycle. The next full frame yields 6 correct windows despite stale line-buffer data.
- Pixel value 11 at (2,2), rest 00 -> first window = 18'h30000, reserved code passed unchanged.
